y_pack_buffer: RTL
==================

Name: y_pack_buffer

Overview:
- Output-side counterpart of the X row buffer: collects 8-bit ALU results, packs four per 32-bit word and queues them in a small FIFO.
- Drains the FIFO to the memory-write/APB side with a valid/ready handshake and an auto-incrementing byte address.
- Sits between the ALU result port and the result-memory writer.

Parameters:
- RES_W, 8, width of one ALU result (one byte lane)
- FIFO_DEPTH, 4, packed-word FIFO entries (power of two, ≥2)
- ROW_WORDS, 8, words per output row; row_done pulses after this many words drain
- APB_ADDR_WIDTH, 13, width of the write address

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; latches base_addr and clears packer/row counters
- base_addr  in  APB_ADDR_WIDTH  byte address of the first word
- alu_valid  in  1  alu_res valid this cycle
- alu_res  in  RES_W  ALU result byte
- alu_ready  out  1  block can accept a result this cycle
- flush  in  1  pulse; zero-pad and push a partial word
- out_valid  out  1  out_data/out_addr valid
- out_ready  in  1  writer accepts the word
- out_data  out  32  packed word
- out_addr  out  APB_ADDR_WIDTH  byte address of out_data
- row_done  out  1  one-cycle pulse when the ROW_WORDS-th word of a row is accepted
- busy  out  1  packer partially filled or FIFO non-empty

Behaviour:
- Reset: all outputs 0 except alu_ready=1. Packer, FIFO pointers/count, address, row and byte counters all 0. Reset mid-transfer discards all content.
- Result accept: alu_valid && alu_ready.
  - Byte i of a word (i = byte_cnt, 0..3) goes to bits [8i+7:8i], so the first result is the LSB.
  - byte_cnt increments; on the 4th byte the word is pushed to the FIFO in the same clock edge and byte_cnt wraps to 0.
- alu_ready = !(byte_cnt==3 && fifo_full && !pop).
  - A completing byte is accepted when the FIFO is full only if a pop occurs in the same cycle.
  - Bytes 0..2 are always accepted; the packer register is independent of the FIFO.
- Pop: out_valid && out_ready.
  - out_valid = FIFO non-empty. out_data is the FIFO head.
  - out_valid and out_data hold stable while out_ready is low.
- Push and pop in the same cycle: count unchanged. Push when full without a pop is impossible by construction.
- Address:
  - out_addr = base + 4*words_popped since start.
  - Increments by 4 on each pop and wraps modulo 2^APB_ADDR_WIDTH.
- Row counter:
  - Counts pops 0..ROW_WORDS-1.
  - On the pop that makes it ROW_WORDS, it wraps to 0 and row_done pulses for 1 cycle, registered (the cycle after the pop edge).
- Flush:
  - With byte_cnt≠0, pushes the partial word with upper unused lanes = 0 and clears byte_cnt.
  - If the FIFO is full without a pop, the push waits until space frees; alu_ready is held 0 while pending.
  - Flush with byte_cnt==0 is a no-op.
  - Flush coinciding with an accepted byte: the byte is packed first, then the word is padded and pushed.
- start:
  - Resets the address to base_addr, the row counter and byte_cnt.
  - Discards any partial word; FIFO contents are kept and are addressed from the new base.
  - Do not assert start with out_valid high; behaviour then is addresses restart for remaining FIFO words.
- Latency: 4th byte accepted at edge N → out_valid high after edge N (visible cycle N+1) if the FIFO was empty.
- busy = (byte_cnt≠0) || FIFO non-empty || flush pending.

Test Plan:
- Basic pack: start base=0x100; feed 0x11,0x22,0x33,0x44 with out_ready=1 → out_data=0x44332211, out_addr=0x100 one cycle after the 4th byte.
- Backpressure: out_ready=0; feed 20 bytes continuously.
  - alu_ready drops on byte 20 (5th word) while the FIFO holds 4.
  - Raising out_ready drains words at 0x100,0x104,0x108,0x10C, then the 5th word, with no loss or duplication.
- Simultaneous push/pop with the FIFO full: the 4th byte is accepted in the same cycle as a pop → count stays 4, data order preserved.
- Flush: feed 0xAA,0xBB, pulse flush → out_data=0x0000BBAA; busy falls after the pop.
- Row/wrap: ROW_WORDS=8, 32 bytes → row_done pulses once, after the 8th pop. base=0x1FFC with 2 words → addresses 0x1FFC, then 0x0000.
- Reset mid-operation: assert rst with 3 words queued and 2 bytes packed → next cycle out_valid=0, busy=0, alu_ready=1, out_addr=0.

Source files
------------

// File: rtl/y_pack_buffer.sv
// rtl/y_pack_buffer.sv - packs ALU result bytes into 32-bit words and drains them through a small FIFO
module y_pack_buffer #(
    parameter int RES_W          = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int ROW_WORDS      = 8,
    parameter int APB_ADDR_WIDTH = 13
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [APB_ADDR_WIDTH-1:0] base_addr,
    input  logic                      alu_valid,
    input  logic [RES_W-1:0]          alu_res,
    output logic                      alu_ready,
    input  logic                      flush,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4*RES_W-1:0]        out_data,
    output logic [APB_ADDR_WIDTH-1:0] out_addr,
    output logic                      row_done,
    output logic                      busy
);
    localparam int WORD_W = 4 * RES_W;
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int ROW_W  = (ROW_WORDS > 1) ? $clog2(ROW_WORDS) : 1;

    logic [1:0]                byte_cnt_q, byte_cnt_d;
    logic [WORD_W-1:0]         pack_q, pack_d;
    logic [WORD_W-1:0]         mem_q [FIFO_DEPTH];
    logic [WORD_W-1:0]         mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]            count_q, count_d;
    logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ROW_W-1:0]          row_cnt_q, row_cnt_d;
    logic                      row_done_q, row_done_d;
    logic                      flush_pend_q, flush_pend_d;

    logic              fifo_full, fifo_empty, pop, accept, push;
    logic [2:0]        eff_cnt;
    logic [WORD_W-1:0] byte_word, eff_word;

    assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop        = !fifo_empty && out_ready;
    // A completing byte needs a free FIFO slot; a pending flush owns the packer.
    assign alu_ready  = !flush_pend_q && !(byte_cnt_q == 2'd3 && fifo_full && !pop);
    assign accept     = alu_valid && alu_ready;

    assign out_valid = !fifo_empty;
    assign out_data  = mem_q[rd_ptr_q];
    assign out_addr  = addr_q;
    assign row_done  = row_done_q;
    assign busy      = (byte_cnt_q != 2'd0) || !fifo_empty || flush_pend_q;

    always_comb begin
        byte_word = pack_q;
        for (int i = 0; i < 4; i++) begin
            if (byte_cnt_q == 2'(i)) byte_word[i*RES_W +: RES_W] = alu_res;
        end
        eff_cnt  = {1'b0, byte_cnt_q} + (accept ? 3'd1 : 3'd0);
        eff_word = accept ? byte_word : pack_q;

        push         = 1'b0;
        pack_d       = eff_word;
        byte_cnt_d   = eff_cnt[1:0];
        flush_pend_d = 1'b0;
        if (eff_cnt == 3'd4) begin
            push       = 1'b1;
            pack_d     = '0;
            byte_cnt_d = 2'd0;
        end else if ((flush || flush_pend_q) && eff_cnt != 3'd0) begin
            if (!fifo_full || pop) begin
                push       = 1'b1;
                pack_d     = '0;
                byte_cnt_d = 2'd0;
            end else begin
                flush_pend_d = 1'b1;
            end
        end
        if (start) begin
            push         = 1'b0;
            pack_d       = '0;
            byte_cnt_d   = 2'd0;
            flush_pend_d = 1'b0;
        end

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = eff_word;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase

        addr_d     = addr_q;
        row_cnt_d  = row_cnt_q;
        row_done_d = 1'b0;
        if (pop) begin
            addr_d = addr_q + APB_ADDR_WIDTH'(4);
            if (row_cnt_q == ROW_W'(ROW_WORDS - 1)) begin
                row_cnt_d  = '0;
                row_done_d = 1'b1;
            end else begin
                row_cnt_d = row_cnt_q + ROW_W'(1);
            end
        end
        if (start) begin
            addr_d    = base_addr;
            row_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            byte_cnt_q   <= '0;
            pack_q       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            addr_q       <= '0;
            row_cnt_q    <= '0;
            row_done_q   <= 1'b0;
            flush_pend_q <= 1'b0;
        end else begin
            byte_cnt_q   <= byte_cnt_d;
            pack_q       <= pack_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            addr_q       <= addr_d;
            row_cnt_q    <= row_cnt_d;
            row_done_q   <= row_done_d;
            flush_pend_q <= flush_pend_d;
        end
    end
endmodule
